// File: rtl/arb_requester_if.sv
// arb_requester_if: local job handshake plus the arbiter request/grant pair
// that arb_requester sits between. The requester itself uses the master
// modport. The slave modport is the view of whatever drives jobs and
// grants into it.
interface arb_requester_if #(
    parameter int unsigned LEN_W = 4
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             gnt;
    logic             req;
    logic             busy;
    logic             beat;
    logic [LEN_W-1:0] beats_left;
    logic             done;
    logic             timeout;

    modport master (
        input  start,
        input  len,
        input  gnt,
        output req,
        output busy,
        output beat,
        output beats_left,
        output done,
        output timeout
    );

    modport slave (
        output start,
        output len,
        output gnt,
        input  req,
        input  busy,
        input  beat,
        input  beats_left,
        input  done,
        input  timeout
    );
endinterface

// File: rtl/arb_requester.sv
// arb_requester: accepts a burst job of len beats and requests the arbiter.
// It moves one beat per granted cycle and releases the request after the
// last beat. It will not go idle until the grant has dropped, so a grant
// that lags behind is never mistaken for a new transfer.
// Build macro REQ_TIMEOUT_EN adds an optional grant-wait limit. When it is
// set, a job that waits TIMEOUT cycles in REQ without a grant is aborted.
module arb_requester #(
    parameter int unsigned LEN_W   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic            clock,
    input  logic            reset,
    arb_requester_if.master bus
);
    localparam logic [3:0] ST_IDLE = 4'b0001;
    localparam logic [3:0] ST_REQ  = 4'b0010;
    localparam logic [3:0] ST_XFER = 4'b0100;
    localparam logic [3:0] ST_REL  = 4'b1000;

    logic [3:0]       state;
    logic [3:0]       state_nxt;
    logic [LEN_W-1:0] beats_left;
    logic [LEN_W-1:0] beats_nxt;
    logic             done_q;
    logic             done_nxt;
    logic             start_ok;
    logic             last_beat;

    assign start_ok  = bus.start && (bus.len != '0);
    assign last_beat = (beats_left <= LEN_W'(1));

`ifdef REQ_TIMEOUT_EN
    localparam int unsigned    CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0] WAIT_LIM = (CNT_W + 1)'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;
    logic [CNT_W-1:0] wait_nxt;
    logic [CNT_W:0]   wait_inc;
    logic             timeout_q;
    logic             timeout_nxt;

    // Abort is decided on the incremented count. The pulse therefore lands
    // TIMEOUT edges after entering REQ, not one edge later.
    assign wait_inc = {1'b0, wait_cnt} + (CNT_W + 1)'(1);
`else
    // TIMEOUT has no effect unless the grant-wait limit is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    // Next-state, burst-count and pulse decode for the request FSM
    always_comb begin
        state_nxt = state;
        beats_nxt = beats_left;
        done_nxt  = 1'b0;
`ifdef REQ_TIMEOUT_EN
        wait_nxt    = wait_cnt;
        timeout_nxt = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (start_ok) begin
                    state_nxt = ST_REQ;
                    beats_nxt = bus.len;
`ifdef REQ_TIMEOUT_EN
                    wait_nxt = '0;
`endif
                end
            end
            ST_REQ: begin
                if (bus.gnt) begin
                    state_nxt = ST_XFER;
                end
`ifdef REQ_TIMEOUT_EN
                else if (wait_inc >= WAIT_LIM) begin
                    state_nxt   = ST_REL;
                    beats_nxt   = '0;
                    timeout_nxt = 1'b1;
                    wait_nxt    = '0;
                end else begin
                    wait_nxt = wait_inc[CNT_W-1:0];
                end
`endif
            end
            ST_XFER: begin
                if (bus.gnt) begin
                    if (last_beat) begin
                        state_nxt = ST_REL;
                        beats_nxt = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        beats_nxt = beats_left - LEN_W'(1);
                    end
                end else begin
                    // A grant dropout returns to REQ with the remaining count kept.
                    state_nxt = ST_REQ;
`ifdef REQ_TIMEOUT_EN
                    wait_nxt = '0;
`endif
                end
            end
            ST_REL: begin
                if (!bus.gnt) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                beats_nxt = '0;
            end
        endcase
    end

    // State, beat count and one-cycle pulses, with an asynchronous clear
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            done_q     <= 1'b0;
        end else begin
            state      <= state_nxt;
            beats_left <= beats_nxt;
            done_q     <= done_nxt;
        end
    end

`ifdef REQ_TIMEOUT_EN
    // Grant-wait counter and timeout pulse
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wait_cnt  <= wait_nxt;
            timeout_q <= timeout_nxt;
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign bus.timeout = 1'b0;
`endif

    // req is decoded from the registered state. It therefore changes only
    // on a clock edge, or immediately on reset.
    assign bus.req        = (state == ST_REQ) || (state == ST_XFER);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.beat       = (state == ST_XFER) && bus.gnt;
    assign bus.beats_left = beats_left;
    assign bus.done       = done_q;

    // Structural invariants of the FSM
    a_onehot : assert property (@(posedge clock) disable iff (reset)
        $onehot(state));
    a_idle_empty : assert property (@(posedge clock) disable iff (reset)
        (state == ST_IDLE) |-> (beats_left == '0));
    a_done_in_rel : assert property (@(posedge clock) disable iff (reset)
        bus.done |-> (state == ST_REL));
    a_timeout_in_rel : assert property (@(posedge clock) disable iff (reset)
        bus.timeout |-> (state == ST_REL));
endmodule

// File: doc/arb_requester.md
ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter LEN_W, default 4, SHALL set the burst-length field width.
REQ-002 Parameter TIMEOUT, default 15, SHALL set the grant-wait limit in clock cycles; it is used only when REQ_TIMEOUT_EN is defined.
REQ-003 Port clock, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: reset SHALL be asynchronous and active-high.
REQ-005 Port start, input, 1: single-cycle job request from the local side.
REQ-006 Port len, input, LEN_W: number of beats in the job; sampled only when start is accepted.
REQ-007 Port gnt, input, 1: grant from the arbiter; may lag req by 1 or more cycles.
REQ-008 Port req, output, 1: request to the arbiter.
REQ-009 Port busy, output, 1: high whenever state is not IDLE.
REQ-010 Port beat, output, 1: high for each cycle in which a beat is transferred.
REQ-011 Port beats_left, output, LEN_W: number of beats remaining in the job.
REQ-012 Port done, output, 1: one-cycle pulse when a job completes.
REQ-013 Port timeout, output, 1: one-cycle pulse when a job is aborted for lack of grant.

Function
REQ-014 The FSM SHALL be one-hot with states IDLE=4'b0001, REQ=4'b0010, XFER=4'b0100, REL=4'b1000, and every unlisted encoding SHALL return to IDLE.
REQ-015 In IDLE, start=1 with len!=0 SHALL load beats_left=len, set req=1 on the next edge and enter REQ.
REQ-016 In IDLE, start=1 with len==0 SHALL be ignored: no state change and no done pulse.
REQ-017 start SHALL be ignored in any state other than IDLE.
REQ-018 In REQ, req SHALL stay 1, and gnt=1 SHALL move the FSM to XFER on the next edge.
REQ-019 In XFER with gnt=1, each cycle SHALL assert beat (combinational from state and gnt) and decrement beats_left by 1.
REQ-020 In XFER, a beat with beats_left==1 SHALL deassert req on the next edge, pulse done for exactly that next cycle, and enter REL.
REQ-021 In XFER, gnt=0 SHALL produce no beat, leave beats_left unchanged, keep req=1, and return the FSM to REQ to resume the remaining beats.
REQ-022 In REL, req SHALL be 0, and the FSM SHALL return to IDLE on the first cycle gnt=0, so a lagging grant is never reused.
REQ-023 beats_left SHALL never wrap below 0 and SHALL read 0 in IDLE after completion.
REQ-024 Total req-high time for a job of len N with immediate grant SHALL be N + (grant latency) cycles.

Reset
REQ-025 Asserting reset SHALL immediately force state=IDLE, req=0, beat=0, beats_left=0, done=0, timeout=0, and the wait counter to 0.
REQ-026 Reset asserted mid-job SHALL abandon the job with no done or timeout pulse.
REQ-027 After reset deasserts, the first start SHALL be accepted on the first rising edge.

Configuration
REQ-028 Macro REQ_TIMEOUT_EN: when defined, a wait counter SHALL clear on entering REQ and increment on each REQ cycle with gnt=0.
REQ-029 With REQ_TIMEOUT_EN defined, when the wait counter reaches TIMEOUT the FSM SHALL drop req, pulse timeout for 1 cycle, clear beats_left, and enter REL.
REQ-030 With REQ_TIMEOUT_EN defined, the wait counter SHALL NOT run in XFER.
REQ-031 Without REQ_TIMEOUT_EN, the FSM SHALL wait in REQ indefinitely, no wait counter SHALL exist, and timeout SHALL be tied to 0.

Verification
REQ-032 Basic job: start with len=3, gnt rising 2 cycles after req -> 3 beat cycles, beats_left 3->2->1->0, one done pulse, req low, then IDLE once gnt=0.
REQ-033 Grant dropout: len=4, gnt low for 2 cycles after beat 2 -> FSM returns to REQ with beats_left=2, resumes, and produces exactly 4 beats total and one done pulse.
REQ-034 Ignored starts: start with len=0 in IDLE, and start with len=5 while busy -> no state change; the in-flight job completes unaffected.
REQ-035 Async reset: reset pulsed mid-XFER between clock edges with len=6 after 3 beats -> req=0 and beats_left=0 immediately, with no done pulse.
REQ-036 Timeout, macro defined, TIMEOUT=15: gnt held 0 -> timeout pulses 15 cycles after entering REQ, req=0, no beats, FSM returns to IDLE.
REQ-037 No timeout, macro undefined: gnt held 0 for 100 cycles -> req stays 1 and timeout stays 0.
REQ-038 Lagging grant: gnt stays 1 for 2 cycles after done -> no extra beats, and the FSM stays in REL until gnt=0.
